// File: rtl/relm_fifo_mc_pkg.sv
// Shared constants for the multi-channel ReLM FIFO I/O bridge.
package relm_fifo_mc_pkg;

  localparam logic [1:0] CMD_POP   = 2'd0;
  localparam logic [1:0] CMD_PEEK  = 2'd1;
  localparam logic [1:0] CMD_LEVEL = 2'd2;
  localparam logic [1:0] CMD_FLUSH = 2'd3;

  // Strobe (push/pop request) and retry flag share the bit just above the data word.
  function automatic int unsigned flag_bit(input int unsigned wd);
    return wd;
  endfunction

endpackage

// File: rtl/relm_fifo_mc_if.sv
// Push/pop port bus between the ReLM ring and the multi-channel FIFO bridge.
interface relm_fifo_mc_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned WD  = 32
);
  logic [NCH*(WD+1)-1:0] push_d;
  logic [NCH-1:0]        push_retry;
  logic [NCH*(WD+1)-1:0] pop_d;
  logic [NCH*(WD+1)-1:0] pop_q;
  logic [NCH-1:0]        wm_out;

  modport master (output push_d, output pop_d, input push_retry, input pop_q, input wm_out);
  modport slave  (input push_d, input pop_d, output push_retry, output pop_q, output wm_out);
endinterface

// File: rtl/relm_fifo_mc_ch.sv
// One show-ahead FIFO channel: pointers, count, flags, RAM and pop command decode.
// Watermark output is built only when RELM_FIFO_MC_WMARK_EN is defined.
module relm_fifo_mc_ch
  import relm_fifo_mc_pkg::*;
#(
  parameter int unsigned WAD = 4,
  parameter int unsigned WD  = 32,
  parameter int unsigned WM  = 12
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_valid_i,
  input  logic [WD-1:0] push_data_i,
  output logic          push_retry_o,
  input  logic          pop_req_i,
  input  logic [1:0]    pop_cmd_i,
  output logic [WD:0]   pop_q_o,
  output logic          wm_o
);
  localparam int unsigned Depth = 2 ** WAD;
  typedef logic [WAD:0] ptr_t;
  localparam ptr_t One = ptr_t'(1);

  ptr_t rp_q, rp_d, wp_q, wp_d, cnt_q, cnt_d;
  logic empty_q, empty_d, full_q, full_d;
  logic pop_do, flush_do, push_do;
  logic [WD-1:0] mem_q [Depth];
  logic [WD-1:0] rdata_q, rdata_d;

  always_comb begin
    pop_do       = rst_n_i & pop_req_i & (pop_cmd_i == CMD_POP) & ~empty_q;
    flush_do     = rst_n_i & pop_req_i & (pop_cmd_i == CMD_FLUSH);
    push_retry_o = (full_q & ~pop_do) | flush_do | ~rst_n_i;
    push_do      = push_valid_i & ~push_retry_o;
    rp_d  = rp_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (flush_do) begin
      rp_d  = wp_q;
      cnt_d = '0;
    end else begin
      if (pop_do)  rp_d = rp_q + One;
      if (push_do) wp_d = wp_q + One;
      case ({push_do, pop_do})
        2'b10:   cnt_d = cnt_q + One;
        2'b01:   cnt_d = cnt_q - One;
        default: cnt_d = cnt_q;
      endcase
    end
    // A fresh word into an empty channel needs one extra cycle to reach the RAM output.
    empty_d = (cnt_d == '0) | (cnt_q == '0);
    full_d  = (cnt_d == ptr_t'(Depth));
    // Write-through keeps the prefetched head correct when popping onto the slot being written.
    rdata_d = (push_do && (wp_q[WAD-1:0] == rp_d[WAD-1:0])) ? push_data_i
                                                             : mem_q[rp_d[WAD-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rp_q    <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_do) mem_q[wp_q[WAD-1:0]] <= push_data_i;
    rdata_q <= rdata_d;
  end

  always_comb begin
    pop_q_o = '0;
    if (!rst_n_i) begin
      pop_q_o = {1'b1, {WD{1'b0}}};
    end else if (pop_req_i) begin
      case (pop_cmd_i)
        CMD_POP, CMD_PEEK: pop_q_o = empty_q ? {1'b1, {WD{1'b0}}} : {1'b0, rdata_q};
        default:           pop_q_o = {1'b0, WD'(cnt_q)};
      endcase
    end
  end

`ifdef RELM_FIFO_MC_WMARK_EN
  logic wm_q, wm_d;

  always_comb wm_d = (32'(cnt_d) >= WM);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) wm_q <= 1'b0;
    else          wm_q <= wm_d;
  end

  assign wm_o = wm_q & rst_n_i;
`else
  // Constant 0; WM is referenced only so both builds share one parameter list.
  assign wm_o = 1'b0 && (WM != 0);
`endif

endmodule

// File: rtl/relm_fifo_mc_io.sv
// Multi-channel FIFO I/O bridge: slices the ring push/pop buses onto NCH independent channels.
// Optional per-channel watermark output enabled by RELM_FIFO_MC_WMARK_EN.
module relm_fifo_mc_io
  import relm_fifo_mc_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned WAD = 4,
  parameter int unsigned WD  = 32,
  parameter int unsigned WM  = 12
) (
  input logic            clk,
  input logic            rst_n_in,
  relm_fifo_mc_if.slave  bus
);
  localparam int unsigned W = WD + 1;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    // Pop payload only carries the command in its low two bits.
    logic [WD-3:0] unused_pop_d;
    assign unused_pop_d = bus.pop_d[c*W+2 +: WD-2];

    relm_fifo_mc_ch #(
      .WAD (WAD),
      .WD  (WD),
      .WM  (WM)
    ) u_ch (
      .clk_i        (clk),
      .rst_n_i      (rst_n_in),
      .push_valid_i (bus.push_d[c*W + flag_bit(WD)]),
      .push_data_i  (bus.push_d[c*W +: WD]),
      .push_retry_o (bus.push_retry[c]),
      .pop_req_i    (bus.pop_d[c*W + flag_bit(WD)]),
      .pop_cmd_i    (bus.pop_d[c*W +: 2]),
      .pop_q_o      (bus.pop_q[c*W +: W]),
      .wm_o         (bus.wm_out[c])
    );
  end

endmodule

// File: tb/tb_relm_fifo_mc_io.sv
// Directed bench for relm_fifo_mc_io with a per-channel scoreboard of pushed words.
module tb_relm_fifo_mc_io;
  import relm_fifo_mc_pkg::*;

  localparam int unsigned NCH = 2;
  localparam int unsigned WAD = 2;
  localparam int unsigned WD  = 32;
  localparam int unsigned WM  = 3;
  localparam int unsigned W   = WD + 1;
`ifdef RELM_FIFO_MC_WMARK_EN
  localparam logic WmOn = 1'b1;
`else
  localparam logic WmOn = 1'b0;
`endif
  localparam logic [WD:0] Retry = {1'b1, {WD{1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [WD-1:0] sb0[$];
  logic [WD-1:0] sb1[$];

  always #5 clk = ~clk;

  relm_fifo_mc_if #(.NCH(NCH), .WD(WD)) bus ();

  relm_fifo_mc_io #(.NCH(NCH), .WAD(WAD), .WD(WD), .WM(WM)) dut (
    .clk      (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [WD:0] obs, input logic [WD:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WD:0] popq(input int ch);
    return bus.pop_q[ch*W +: W];
  endfunction

  function automatic logic [WD:0] word(input logic [WD-1:0] d);
    return {1'b0, d};
  endfunction

  task automatic idle_all();
    bus.push_d = '0;
    bus.pop_d  = '0;
  endtask

  task automatic drive_push(input int ch, input logic [WD-1:0] d);
    bus.push_d[ch*W +: W] = {1'b1, d};
  endtask

  task automatic drive_pop(input int ch, input logic [1:0] cmd);
    bus.pop_d[ch*W +: W] = {1'b1, {(WD-2){1'b0}}, cmd};
  endtask

  // Drive a push and record it in the scoreboard.
  task automatic push_w(input int ch, input logic [WD-1:0] d);
    drive_push(ch, d);
    if (ch == 0) sb0.push_back(d);
    else         sb1.push_back(d);
  endtask

  // Compare a POP/PEEK result against the scoreboard head.
  task automatic expect_head(input int ch, input logic consume, input string tag);
    logic [WD-1:0] e;
    int n;
    n = (ch == 0) ? sb0.size() : sb1.size();
    if (n == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %h expected scoreboard entry (none)", tag, popq(ch));
    end else begin
      e = (ch == 0) ? sb0[0] : sb1[0];
      if (consume) begin
        if (ch == 0) void'(sb0.pop_front());
        else         void'(sb1.pop_front());
      end
      check(tag, popq(ch), word(e));
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_all();
  endtask

  initial begin
    idle_all();
    tick();
    drive_push(0, 32'h99);
    drive_pop(0, CMD_POP);
    settle();
    check("rst_push_retry", {31'b0, bus.push_retry}, 33'd3);
    check("rst_pop_retry", {32'b0, popq(0)[WD]}, 33'd1);
    check("rst_wm", {31'b0, bus.wm_out}, 33'd0);
    tick();
    rst_n = 1'b1;

    // Basic ordering and two-cycle first-word latency
    drive_pop(0, CMD_POP);
    settle(); check("t1_empty_pop", popq(0), Retry); tick();
    push_w(0, 32'h11);
    settle(); check("t1_push_ok", {32'b0, bus.push_retry[0]}, 33'd0); tick();
    push_w(0, 32'h22); drive_pop(0, CMD_POP);
    settle(); check("t1_latency_n1", popq(0), Retry); tick();
    drive_pop(0, CMD_POP);
    settle(); expect_head(0, 1'b1, "t1_pop_11"); tick();
    drive_pop(0, CMD_POP);
    settle(); expect_head(0, 1'b1, "t1_pop_22"); tick();
    drive_pop(0, CMD_POP);
    settle(); check("t1_pop_empty", popq(0), Retry); tick();

    // Fill ch1, full retry, simultaneous push+pop on full
    for (int i = 0; i < 4; i++) begin
      push_w(1, 32'h101 + 32'(i));
      settle(); check("t2_push_fill", {32'b0, bus.push_retry[1]}, 33'd0); tick();
    end
    drive_push(1, 32'h105); drive_pop(1, CMD_LEVEL);
    settle();
    check("t2_level4", popq(1), word(32'd4));
    check("t2_full_retry", {32'b0, bus.push_retry[1]}, 33'd1);
    tick();
    push_w(1, 32'h55); drive_pop(1, CMD_POP);
    settle();
    check("t2_full_pushpop_retry", {32'b0, bus.push_retry[1]}, 33'd0);
    expect_head(1, 1'b1, "t2_pop_101");
    tick();
    drive_pop(1, CMD_LEVEL);
    settle(); check("t2_level_still4", popq(1), word(32'd4)); tick();

    // PEEK does not consume
    push_w(0, 32'hAA); tick();
    tick();
    drive_pop(0, CMD_PEEK);
    settle(); expect_head(0, 1'b0, "t3_peek1"); tick();
    drive_pop(0, CMD_PEEK);
    settle(); expect_head(0, 1'b0, "t3_peek2"); tick();
    drive_pop(0, CMD_LEVEL);
    settle(); check("t3_level1", popq(0), word(32'd1)); tick();
    drive_pop(0, CMD_POP);
    settle(); expect_head(0, 1'b1, "t3_pop_aa"); tick();
    drive_pop(0, CMD_LEVEL);
    settle(); check("t3_level0", popq(0), word(32'd0)); tick();

    // FLUSH wins over a simultaneous push
    drive_pop(1, CMD_POP);
    settle(); expect_head(1, 1'b1, "t4_pop_102"); tick();
    drive_push(1, 32'h77); drive_pop(1, CMD_FLUSH);
    settle();
    check("t4_flush_count", popq(1), word(32'd3));
    check("t4_flush_push_retry", {32'b0, bus.push_retry[1]}, 33'd1);
    sb1.delete();
    tick();
    drive_pop(1, CMD_LEVEL);
    settle(); check("t4_level0", popq(1), word(32'd0)); tick();
    drive_pop(1, CMD_POP);
    settle(); check("t4_pop_retry", popq(1), Retry); tick();

    // Stream 10 words through ch0 across pointer wrap; ch1 stays idle
    for (int i = 0; i < 3; i++) begin
      push_w(0, 32'h200 + 32'(i)); drive_pop(1, CMD_LEVEL);
      settle(); check("t5_ch1_level", popq(1), word(32'd0)); tick();
    end
    for (int i = 3; i < 10; i++) begin
      push_w(0, 32'h200 + 32'(i)); drive_pop(0, CMD_POP); drive_pop(1, CMD_LEVEL);
      settle();
      if (i == 3) check("t5_wm_rise", {32'b0, bus.wm_out[0]}, {32'b0, WmOn});
      check("t5_push_ok", {32'b0, bus.push_retry[0]}, 33'd0);
      expect_head(0, 1'b1, "t5_stream_pop");
      check("t5_ch1_level", popq(1), word(32'd0));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive_pop(0, CMD_POP);
      settle();
      if (i == 0) check("t5_wm_high3", {32'b0, bus.wm_out[0]}, {32'b0, WmOn});
      if (i == 1) check("t5_wm_fall", {32'b0, bus.wm_out[0]}, 33'd0);
      expect_head(0, 1'b1, "t5_drain_pop");
      tick();
    end
    drive_pop(0, CMD_POP);
    settle(); check("t5_drained", popq(0), Retry); tick();

    // Synchronous reset with a pending push
    for (int i = 0; i < 3; i++) begin
      push_w(0, 32'h300 + 32'(i)); tick();
    end
    rst_n = 1'b0;
    drive_push(0, 32'h3FF); drive_pop(0, CMD_POP); drive_pop(1, CMD_POP);
    settle();
    check("t6_rst_push_retry", {31'b0, bus.push_retry}, 33'd3);
    check("t6_rst_pop0_retry", {32'b0, popq(0)[WD]}, 33'd1);
    check("t6_rst_pop1_retry", {32'b0, popq(1)[WD]}, 33'd1);
    check("t6_rst_wm", {31'b0, bus.wm_out}, 33'd0);
    tick();
    rst_n = 1'b1;
    sb0.delete();
    drive_pop(0, CMD_LEVEL); drive_pop(1, CMD_LEVEL);
    settle();
    check("t6_level0_ch0", popq(0), word(32'd0));
    check("t6_level0_ch1", popq(1), word(32'd0));
    check("t6_wm_after", {31'b0, bus.wm_out}, 33'd0);
    tick();
    drive_pop(0, CMD_POP);
    settle(); check("t6_pop_retry", popq(0), Retry); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
